tlc_farm_sensor: RTL and testbench
==================================

TLC_FARM_SENSOR -- requirements
Module: tlc_farm_sensor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive synchronized cycles required to change debounced sensor state (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter AGE_WIDTH, default 31, width of RequestAge; matches the controller Count width.
REQ-003 Port Clk  input  1  single system clock; all logic on posedge Clk.
REQ-004 Port Rst  input  1  synchronous, active-low reset; sampled on posedge Clk only.
REQ-005 Port SensorRaw  input  1  asynchronous farm-road vehicle detector, 1 = vehicle present.
REQ-006 Port FarmGreen  input  1  from traffic-light FSM; 1 while farm signal is green; acts as request acknowledge.
REQ-007 Port SensorStable  output  1  debounced vehicle-present level.
REQ-008 Port FarmRequest  output  1  latched service request consumed by the traffic-light FSM.
REQ-009 Port RequestAge  output  AGE_WIDTH  cycles elapsed since FarmRequest rose; saturating.
REQ-010 Port AgeSaturated  output  1  1 when RequestAge equals all-ones.

Function
REQ-011 SensorRaw SHALL pass a 2-flop synchronizer; only the second-flop output (sync) feeds further logic.
REQ-012 Debounce FSM SHALL have four states: ABSENT, QUAL_ON, PRESENT, QUAL_OFF.
REQ-013 ABSENT: sync=1 -> QUAL_ON, debounce counter loaded 1; else stay.
REQ-014 QUAL_ON: sync=0 -> ABSENT, counter cleared; sync=1 and counter==DEBOUNCE_CYCLES-1 -> PRESENT; else counter+1.
REQ-015 PRESENT: sync=0 -> QUAL_OFF, counter loaded 1; else stay.
REQ-016 QUAL_OFF: sync=1 -> PRESENT, counter cleared; sync=0 and counter==DEBOUNCE_CYCLES-1 -> ABSENT; else counter+1.
REQ-017 SensorStable SHALL be registered, 1 in PRESENT and QUAL_OFF, 0 otherwise; a 1-cycle glitch on sync SHALL never toggle it.
REQ-018 Latency: first cycle sync=1 at cycle t (raw high at t-2) -> SensorStable=1 at t+DEBOUNCE_CYCLES if sync held high throughout; same latency for release.
REQ-019 Debounce counter width SHALL be ceil(log2(DEBOUNCE_CYCLES))+1 bits; it SHALL never wrap.
REQ-020 FarmRequest SHALL set on the cycle after SensorStable=1 and FarmGreen=0; it SHALL clear on the cycle after FarmGreen=1.
REQ-021 Simultaneous set condition and FarmGreen=1: clear wins; FarmRequest held 0 for every cycle FarmGreen=1.
REQ-022 After FarmGreen falls with SensorStable still 1, FarmRequest SHALL re-assert one cycle later (vehicle still waiting).
REQ-023 FarmRequest SHALL stay set when SensorStable falls before service (vehicle left); only FarmGreen clears it.
REQ-024 RequestAge SHALL be 0 while FarmRequest=0; load 1 on the first cycle FarmRequest=1; increment each cycle thereafter.
REQ-025 RequestAge SHALL saturate at 2^AGE_WIDTH-1, never wrap; AgeSaturated registered, equals (RequestAge==all-ones).
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-027 Rst=0 at a posedge SHALL force: FSM ABSENT, counter 0, synchronizer flops 0, SensorStable 0, FarmRequest 0, RequestAge 0, AgeSaturated 0.
REQ-028 Reset mid-qualification or mid-request SHALL discard all progress; after Rst=1, a held-high SensorRaw requires full 2+DEBOUNCE_CYCLES cycles again.

Structure
REQ-029 Debounce state encodings (2-bit) and the default DEBOUNCE_CYCLES SHALL live in the shared tlc package alongside the controller state and signal-colour encodings.
REQ-030 Synchronizer plus debounce FSM SHALL be one sub-module, tlc_debounce; request latch and age counter stay in the top.

Verification (DEBOUNCE_CYCLES=4, AGE_WIDTH=4)
REQ-031 SensorRaw 0->1 held at cycle 10, no FarmGreen -> SensorStable=1 at cycle 16, FarmRequest=1 at 17, RequestAge 1,2,3... from 17.
REQ-032 SensorRaw high for 2 cycles then low -> SensorStable and FarmRequest remain 0 throughout.
REQ-033 FarmRequest=1, FarmGreen pulsed high cycles 30-35 with SensorStable=1 -> FarmRequest 0 during 31-36, 1 again at 37, RequestAge restarts at 1.
REQ-034 Request held 20 cycles -> RequestAge reaches 15, stays 15, AgeSaturated=1 from that cycle on.
REQ-035 Rst=0 for one cycle while QUAL_ON counter=3 and FarmRequest=1 -> all outputs 0 next cycle; held-high SensorRaw re-qualifies in 6 cycles.
REQ-036 SensorRaw drops for 1 cycle while PRESENT -> SensorStable stays 1; drop for 4+ cycles -> SensorStable=0, FarmRequest unchanged.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller encodings: controller states, signal colours
// and the farm-road sensor debounce states.
package tlc_pkg;

  typedef enum logic [1:0] {
    CTL_HWY_GREEN  = 2'd0,
    CTL_HWY_YELLOW = 2'd1,
    CTL_FARM_GREEN = 2'd2,
    CTL_FARM_YELLOW = 2'd3
  } ctl_state_e;

  typedef enum logic [1:0] {
    COLOUR_RED    = 2'd0,
    COLOUR_YELLOW = 2'd1,
    COLOUR_GREEN  = 2'd2
  } colour_e;

  typedef enum logic [1:0] {
    DB_ABSENT   = 2'd0,
    DB_QUAL_ON  = 2'd1,
    DB_PRESENT  = 2'd2,
    DB_QUAL_OFF = 2'd3
  } db_state_e;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // A vehicle counts as present until release has fully qualified.
  function automatic logic db_is_present(db_state_e s);
    return (s == DB_PRESENT) || (s == DB_QUAL_OFF);
  endfunction

endpackage

// File: rtl/tlc_farm_sensor_if.sv
// Farm-road sensor bundle between the detector/controller side and the sensor block.
interface tlc_farm_sensor_if #(
  parameter int AGE_WIDTH = 31
);
  logic                 SensorRaw;
  logic                 FarmGreen;
  logic                 SensorStable;
  logic                 FarmRequest;
  logic [AGE_WIDTH-1:0] RequestAge;
  logic                 AgeSaturated;

  modport master (
    output SensorRaw,
    output FarmGreen,
    input  SensorStable,
    input  FarmRequest,
    input  RequestAge,
    input  AgeSaturated
  );

  modport slave (
    input  SensorRaw,
    input  FarmGreen,
    output SensorStable,
    output FarmRequest,
    output RequestAge,
    output AgeSaturated
  );
endinterface

// File: rtl/tlc_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM; the stable level
// only changes after DEBOUNCE_CYCLES consecutive agreeing synchronized samples.
module tlc_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_q;
  logic             sync_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= raw_i;
      sync_q      <= sync_meta_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= DB_ABSENT;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Counter is bounded by CNT_LAST in both qualifying states, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DB_ABSENT: begin
        if (sync_q) begin
          state_d = DB_QUAL_ON;
          cnt_d   = CNT_ONE;
        end
      end
      DB_QUAL_ON: begin
        if (!sync_q) begin
          state_d = DB_ABSENT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_PRESENT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DB_PRESENT: begin
        if (!sync_q) begin
          state_d = DB_QUAL_OFF;
          cnt_d   = CNT_ONE;
        end
      end
      DB_QUAL_OFF: begin
        if (sync_q) begin
          state_d = DB_PRESENT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_ABSENT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    stable_d = db_is_present(state_d);
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/tlc_farm_sensor.sv
// Farm-road vehicle sensor: debounced presence, latched service request that the
// farm green acknowledges, and a saturating age of the outstanding request.
module tlc_farm_sensor
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int AGE_WIDTH       = 31
) (
  input  logic               Clk,
  input  logic               Rst,
  tlc_farm_sensor_if.slave   bus
);

  localparam logic [AGE_WIDTH-1:0] AGE_ONE = AGE_WIDTH'(1);

  logic                 stable;
  logic                 req_q, req_d;
  logic [AGE_WIDTH-1:0] age_q, age_d;
  logic                 sat_q, sat_d;

  tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk      (Clk),
    .Rst      (Rst),
    .raw_i    (bus.SensorRaw),
    .stable_o (stable)
  );

  // Green acknowledge dominates; a vanished vehicle does not withdraw the request.
  always_comb begin
    req_d = req_q;
    if (bus.FarmGreen) begin
      req_d = 1'b0;
    end else if (stable) begin
      req_d = 1'b1;
    end

    age_d = '0;
    if (req_d) begin
      if (!req_q) begin
        age_d = AGE_ONE;
      end else if (&age_q) begin
        age_d = age_q;
      end else begin
        age_d = age_q + AGE_ONE;
      end
    end

    sat_d = &age_d;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      req_q <= 1'b0;
      age_q <= '0;
      sat_q <= 1'b0;
    end else begin
      req_q <= req_d;
      age_q <= age_d;
      sat_q <= sat_d;
    end
  end

  assign bus.SensorStable = stable;
  assign bus.FarmRequest  = req_q;
  assign bus.RequestAge   = age_q;
  assign bus.AgeSaturated = sat_q;

endmodule

// File: tb/tb_tlc_farm_sensor.sv
// Directed bench for tlc_farm_sensor with DEBOUNCE_CYCLES=4, AGE_WIDTH=4.
module tb_tlc_farm_sensor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tlc_farm_sensor_if #(.AGE_WIDTH(4)) bus ();

  tlc_farm_sensor #(
    .DEBOUNCE_CYCLES(4),
    .AGE_WIDTH(4)
  ) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle index below refers to the interval right after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.SensorRaw = 1'b1;
    bus.FarmGreen = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.SensorStable !== 1'b0) begin
      errors++; $display("FAIL reset_stable: got %b want 0", bus.SensorStable);
    end
    checks++;
    if (bus.FarmRequest !== 1'b0) begin
      errors++; $display("FAIL reset_request: got %b want 0", bus.FarmRequest);
    end
    checks++;
    if (bus.RequestAge !== 4'd0) begin
      errors++; $display("FAIL reset_age: got %0d want 0", bus.RequestAge);
    end
    checks++;
    if (bus.AgeSaturated !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got %b want 0", bus.AgeSaturated);
    end
    bus.SensorRaw = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.SensorStable !== 1'b0 || bus.FarmRequest !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: stable=%b req=%b want 0 0",
                         bus.SensorStable, bus.FarmRequest);
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_short_pulse();
    bus.SensorRaw = 1'b1;
    tick();
    tick();
    bus.SensorRaw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (bus.SensorStable !== 1'b0) begin
        errors++; $display("FAIL pulse_stable k=%0d: got %b want 0", k, bus.SensorStable);
      end
      checks++;
      if (bus.FarmRequest !== 1'b0) begin
        errors++; $display("FAIL pulse_request k=%0d: got %b want 0", k, bus.FarmRequest);
      end
    end
    $display("test_short_pulse done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Raw rises at cycle 0: stable at 6 (2 sync + 4 debounce), request/age at 7.
  task automatic test_qualify();
    logic       exp_stable;
    logic       exp_req;
    logic [3:0] exp_age;
    bus.SensorRaw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_stable = (k >= 6);
      exp_req    = (k >= 7);
      exp_age    = (k >= 7) ? 4'(k - 6) : 4'd0;
      checks++;
      if (bus.SensorStable !== exp_stable) begin
        errors++; $display("FAIL qual_stable k=%0d: got %b want %b", k, bus.SensorStable, exp_stable);
      end
      checks++;
      if (bus.FarmRequest !== exp_req) begin
        errors++; $display("FAIL qual_request k=%0d: got %b want %b", k, bus.FarmRequest, exp_req);
      end
      checks++;
      if (bus.RequestAge !== exp_age) begin
        errors++; $display("FAIL qual_age k=%0d: got %0d want %0d", k, bus.RequestAge, exp_age);
      end
    end
    $display("test_qualify done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Continues from test_qualify; age = k-6 clamped at 15 (reached at k=21).
  task automatic test_saturation();
    logic [3:0] exp_age;
    logic       exp_sat;
    for (int k = 11; k <= 30; k++) begin
      tick();
      exp_age = (k - 6 >= 15) ? 4'd15 : 4'(k - 6);
      exp_sat = (k >= 21);
      checks++;
      if (bus.RequestAge !== exp_age) begin
        errors++; $display("FAIL sat_age k=%0d: got %0d want %0d", k, bus.RequestAge, exp_age);
      end
      checks++;
      if (bus.AgeSaturated !== exp_sat) begin
        errors++; $display("FAIL sat_flag k=%0d: got %b want %b", k, bus.AgeSaturated, exp_sat);
      end
    end
    $display("test_saturation done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Green high for cycles 0..5 with vehicle still present: request low 1..6, back at 7.
  task automatic test_ack();
    logic       exp_req;
    logic [3:0] exp_age;
    bus.FarmGreen = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_req = (k >= 7);
      exp_age = (k >= 7) ? 4'(k - 6) : 4'd0;
      checks++;
      if (bus.FarmRequest !== exp_req) begin
        errors++; $display("FAIL ack_request k=%0d: got %b want %b", k, bus.FarmRequest, exp_req);
      end
      checks++;
      if (bus.RequestAge !== exp_age) begin
        errors++; $display("FAIL ack_age k=%0d: got %0d want %0d", k, bus.RequestAge, exp_age);
      end
      checks++;
      if (bus.AgeSaturated !== 1'b0) begin
        errors++; $display("FAIL ack_sat k=%0d: got %b want 0", k, bus.AgeSaturated);
      end
      if (k == 6) bus.FarmGreen = 1'b0;
    end
    $display("test_ack done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_glitch();
    bus.SensorRaw = 1'b0;
    tick();
    bus.SensorRaw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.SensorStable !== 1'b1) begin
        errors++; $display("FAIL glitch_stable k=%0d: got %b want 1", k, bus.SensorStable);
      end
    end
    $display("test_glitch done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Vehicle leaves without service: stable drops at 6, request stays latched.
  task automatic test_release();
    logic exp_stable;
    bus.SensorRaw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_stable = (k < 6);
      checks++;
      if (bus.SensorStable !== exp_stable) begin
        errors++; $display("FAIL release_stable k=%0d: got %b want %b", k, bus.SensorStable, exp_stable);
      end
      checks++;
      if (bus.FarmRequest !== 1'b1) begin
        errors++; $display("FAIL release_request k=%0d: got %b want 1", k, bus.FarmRequest);
      end
    end
    $display("test_release done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Reset while qualifying (counter=3) with a latched request; full requalification after.
  task automatic test_reset_mid();
    logic exp_stable;
    logic exp_req;
    bus.SensorRaw = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    checks++;
    if (bus.SensorStable !== 1'b0 || bus.FarmRequest !== 1'b1) begin
      errors++; $display("FAIL pre_reset: stable=%b req=%b want 0 1", bus.SensorStable, bus.FarmRequest);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.SensorStable !== 1'b0 || bus.FarmRequest !== 1'b0 ||
        bus.RequestAge !== 4'd0 || bus.AgeSaturated !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: stable=%b req=%b age=%0d sat=%b want 0 0 0 0",
                         bus.SensorStable, bus.FarmRequest, bus.RequestAge, bus.AgeSaturated);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_stable = (k >= 6);
      exp_req    = (k >= 7);
      checks++;
      if (bus.SensorStable !== exp_stable) begin
        errors++; $display("FAIL requal_stable k=%0d: got %b want %b", k, bus.SensorStable, exp_stable);
      end
      checks++;
      if (bus.FarmRequest !== exp_req) begin
        errors++; $display("FAIL requal_request k=%0d: got %b want %b", k, bus.FarmRequest, exp_req);
      end
    end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.SensorRaw = 1'b0;
    bus.FarmGreen = 1'b0;
    tick();
    test_reset();
    test_short_pulse();
    test_qualify();
    test_saturation();
    test_ack();
    test_glitch();
    test_release();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
